// File: rtl/qspi_target.sv
// qspi_target: a QSPI responder that runs entirely in the PCLK domain.
// SCLK, CS_N and the IO lines are oversampled. The block decodes 1/2/4-bit
// read and write frames and serves them from a small byte memory that can
// also be read through a debug port.
module qspi_target #(
  parameter int AW        = 4,
  parameter int DUMMY_CYC = 4
) (
  input  logic          PCLK,
  input  logic          PRESET,
  input  logic          SCLK,
  input  logic          CS_N,
  input  logic [3:0]    QSPI_QIN,
  output logic [3:0]    QSPI_QOUT,
  output logic [3:0]    QSPI_QOE,
  input  logic [AW-1:0] dbg_addr,
  output logic [7:0]    dbg_data,
  output logic          busy,
  output logic          cmd_err,
  output logic          xfer_done
);

  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_ADDR, S_DUMMY, S_RD, S_WR, S_ERR
  } state_t;

  // When DUMMY_CYC is 0 the DUMMY state is never entered, so the wrapped value is harmless.
  localparam logic [7:0] DUMMY_LAST = 8'(DUMMY_CYC - 1);

  // Bit 0 = first sync stage, bit 1 = second stage, bit 2 = previous synced value.
  logic [2:0] sclk_s_q;
  logic [2:0] cs_s_q;
  logic [3:0] qin_s1_q, qin_s2_q;
  logic       sclk_rise, sclk_fall, cs_rise, cs_fall;

  state_t        state_q, state_d;
  logic [7:0]    cnt_q, cnt_d;
  logic [6:0]    sh_q, sh_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [1:0]    wid_q, wid_d;     // 0: 1-bit, 1: 2-bit, 2: 4-bit
  logic          rd_q, rd_d;
  logic          err_q, err_d;
  logic [3:0]    qout_q, qout_d;
  logic [3:0]    qoe_q, qoe_d;
  logic          done_q, done_d;

  logic [7:0] mem_q [2**AW];
  logic       mem_we;

  logic [7:0] byte_in1, byte_inw, rd_byte;
  logic [2:0] shamt;
  logic [3:0] rd_top, rd_chunk, rd_oe;
  logic       last_chunk, op_valid, op_rd;
  logic [1:0] op_wid;

  // Two-stage synchronisers, plus one more flop that feeds the edge detectors.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      sclk_s_q <= 3'b000;
      cs_s_q   <= 3'b111;
      qin_s1_q <= 4'h0;
      qin_s2_q <= 4'h0;
    end else begin
      sclk_s_q <= {sclk_s_q[1:0], SCLK};
      cs_s_q   <= {cs_s_q[1:0], CS_N};
      qin_s1_q <= QSPI_QIN;
      qin_s2_q <= qin_s1_q;
    end
  end

  assign sclk_rise = sclk_s_q[1] & ~sclk_s_q[2];
  assign sclk_fall = ~sclk_s_q[1] & sclk_s_q[2];
  assign cs_rise   = cs_s_q[1] & ~cs_s_q[2];
  assign cs_fall   = ~cs_s_q[1] & cs_s_q[2];

  // Datapath helpers: incoming bytes, the outgoing read chunk, and opcode decode.
  always_comb begin
    byte_in1 = {sh_q, qin_s2_q[0]};
    case (wid_q)
      2'd0:    byte_inw = {sh_q, qin_s2_q[0]};
      2'd1:    byte_inw = {sh_q[5:0], qin_s2_q[1:0]};
      default: byte_inw = {sh_q[3:0], qin_s2_q};
    endcase
    rd_byte = mem_q[addr_q];
    case (wid_q)
      2'd0:    begin shamt = cnt_q[2:0];        last_chunk = (cnt_q == 8'd7); end
      2'd1:    begin shamt = {cnt_q[1:0], 1'b0}; last_chunk = (cnt_q == 8'd3); end
      default: begin shamt = {cnt_q[0], 2'b00};  last_chunk = (cnt_q == 8'd1); end
    endcase
    rd_top = 4'((rd_byte << shamt) >> 4);
    case (wid_q)
      2'd0:    begin rd_chunk = {2'b00, rd_top[3], 1'b0}; rd_oe = 4'b0010; end
      2'd1:    begin rd_chunk = {2'b00, rd_top[3:2]};     rd_oe = 4'b0011; end
      default: begin rd_chunk = rd_top;                   rd_oe = 4'b1111; end
    endcase
    op_valid = 1'b1;
    op_rd    = 1'b0;
    op_wid   = 2'd0;
    case (byte_in1)
      8'h03: begin op_rd = 1'b1; op_wid = 2'd0; end
      8'h3B: begin op_rd = 1'b1; op_wid = 2'd1; end
      8'h6B: begin op_rd = 1'b1; op_wid = 2'd2; end
      8'h02: op_wid = 2'd0;
      8'hA2: op_wid = 2'd1;
      8'h32: op_wid = 2'd2;
      default: op_valid = 1'b0;
    endcase
  end

  // Frame sequencer: next state, counters, output drive and memory write enable.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sh_d    = sh_q;
    addr_d  = addr_q;
    wid_d   = wid_q;
    rd_d    = rd_q;
    err_d   = err_q;
    qout_d  = qout_q;
    qoe_d   = qoe_q;
    done_d  = 1'b0;
    mem_we  = 1'b0;
    if (cs_fall) begin
      // A fall while a frame is open acts as a close followed by a new open.
      done_d  = (state_q != S_IDLE);
      state_d = S_CMD;
      cnt_d   = 8'd0;
      sh_d    = 7'd0;
      err_d   = 1'b0;
      qout_d  = 4'h0;
      qoe_d   = 4'h0;
    end else if (cs_rise) begin
      // The frame closes here, so any SCLK rise in this same cycle is ignored.
      done_d  = (state_q != S_IDLE);
      state_d = S_IDLE;
      cnt_d   = 8'd0;
      qout_d  = 4'h0;
      qoe_d   = 4'h0;
    end else begin
      case (state_q)
        S_CMD: if (sclk_rise) begin
          sh_d  = byte_in1[6:0];
          cnt_d = cnt_q + 8'd1;
          if (cnt_q == 8'd7) begin
            cnt_d = 8'd0;
            rd_d  = op_rd;
            wid_d = op_wid;
            if (op_valid) state_d = S_ADDR;
            else begin
              state_d = S_ERR;
              err_d   = 1'b1;
            end
          end
        end
        S_ADDR: if (sclk_rise) begin
          sh_d  = byte_in1[6:0];
          cnt_d = cnt_q + 8'd1;
          if (cnt_q == 8'd7) begin
            cnt_d  = 8'd0;
            addr_d = byte_in1[AW-1:0];
            if (!rd_q)              state_d = S_WR;
            else if (DUMMY_CYC > 0) state_d = S_DUMMY;
            else                    state_d = S_RD;
          end
        end
        S_DUMMY: if (sclk_rise) begin
          cnt_d = cnt_q + 8'd1;
          if (cnt_q == DUMMY_LAST) begin
            cnt_d   = 8'd0;
            state_d = S_RD;
          end
        end
        S_RD: if (sclk_fall) begin
          qout_d = rd_chunk;
          qoe_d  = rd_oe;
          cnt_d  = cnt_q + 8'd1;
          if (last_chunk) begin
            cnt_d  = 8'd0;
            addr_d = addr_q + AW'(1);
          end
        end
        S_WR: if (sclk_rise) begin
          sh_d  = byte_inw[6:0];
          cnt_d = cnt_q + 8'd1;
          if (last_chunk) begin
            cnt_d  = 8'd0;
            mem_we = 1'b1;
            addr_d = addr_q + AW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // State and control registers.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q <= S_IDLE;
      cnt_q   <= 8'd0;
      sh_q    <= 7'd0;
      addr_q  <= '0;
      wid_q   <= 2'd0;
      rd_q    <= 1'b0;
      err_q   <= 1'b0;
      qout_q  <= 4'h0;
      qoe_q   <= 4'h0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sh_q    <= sh_d;
      addr_q  <= addr_d;
      wid_q   <= wid_d;
      rd_q    <= rd_d;
      err_q   <= err_d;
      qout_q  <= qout_d;
      qoe_q   <= qoe_d;
      done_q  <= done_d;
    end
  end

  // Byte memory: cleared by reset and written when a write byte completes.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      for (int i = 0; i < 2**AW; i++) mem_q[i] <= 8'h00;
    end else if (mem_we) begin
      mem_q[addr_q] <= byte_inw;
    end
  end

  assign dbg_data  = mem_q[dbg_addr];
  assign busy      = (state_q != S_IDLE);
  assign cmd_err   = err_q;
  assign xfer_done = done_q;
  assign QSPI_QOUT = qout_q;
  assign QSPI_QOE  = qoe_q;

endmodule

// File: doc/qspi_target.md
# qspi_target

Synchronous QSPI target (responder) for the `tiny_qspi_apb` master: it decodes SPI/DPI/QPI command frames driven by the master's SCLK/MCS/QOUT and returns read data or stores write data in a small internal byte memory. All QSPI inputs are oversampled in the single PCLK domain. It serves as a synthesizable loopback target for bench and FPGA bring-up of the master, replacing the random-data QIN stub.

## Interface
- AW, 4: memory address width; memory is 2^AW bytes.
- DUMMY_CYC, 4: SCLK cycles inserted between address and data on reads (0 allowed).
- PCLK  in  1  system clock; every input is sampled on its rising edge.
- PRESET  in  1  synchronous, active-high reset.
- SCLK  in  1  QSPI clock from master, asynchronous to PCLK.
- CS_N  in  1  chip select (one MCS bit), active low.
- QSPI_QIN  in  4  IO lines driven by master (master QSPI_QOUT).
- QSPI_QOUT  out  4  IO lines driven by target.
- QSPI_QOE  out  4  per-line output enable, 1 = target drives.
- dbg_addr  in  AW  backdoor memory read address.
- dbg_data  out  8  combinational mem[dbg_addr].
- busy  out  1  high whenever state != IDLE.
- cmd_err  out  1  unknown opcode seen in current frame.
- xfer_done  out  1  one-PCLK pulse when a frame ends.

## Operation
- Input conditioning: SCLK, CS_N and QSPI_QIN each pass through 2 flops; edge detect on the synced SCLK and CS_N yields sclk_rise, sclk_fall, cs_rise and cs_fall single-PCLK strobes.
- SPI mode 0: inputs are sampled on sclk_rise and outputs updated on sclk_fall. Bit order is MSB first.
- Frame layout:
  - opcode: 8 bits on IO0.
  - address: 8 bits on IO0; only the low AW bits are used.
  - reads only: DUMMY_CYC dummy cycles.
  - data bytes: width set by opcode.
- Opcodes:
  - 0x03: read, 1-bit, data out on IO1.
  - 0x3B: read, 2-bit, IO[1:0].
  - 0x6B: read, 4-bit, IO[3:0].
  - 0x02: write, 1-bit, data in on IO0.
  - 0xA2: write, 2-bit.
  - 0x32: write, 4-bit.
  - Any other opcode: go to ERR and set cmd_err.
- States: IDLE, CMD, ADDR, DUMMY, RD, WR, ERR.
  - IDLE -> CMD on cs_fall. This also clears cmd_err and the bit counter.
  - CMD -> ADDR after 8 rises.
  - ADDR -> DUMMY after 8 rises (read, DUMMY_CYC>0), else -> RD or WR.
  - DUMMY -> RD after DUMMY_CYC rises.
  - RD, WR and ERR remain until CS rises.
  - cs_rise in any state -> IDLE. xfer_done pulses if the prior state != IDLE.
- RD:
  - The first sclk_fall in RD drives the top chunk of mem[addr].
  - Each following fall drives the next chunk: 1, 2 or 4 bits per cycle, so 8, 4 or 2 cycles per byte.
  - After the last chunk, addr increments modulo 2^AW and the next fall drives mem[addr+1].
- WR:
  - Chunks shift in on each rise.
  - On the completing rise, mem[addr] is written on the next PCLK, then addr increments modulo 2^AW.
  - A partial byte at cs_rise is discarded; the memory is unchanged.
- QSPI_QOE by read width: 1-bit 4'b0010, 2-bit 4'b0011, 4-bit 4'b1111.
  - Asserted from the first RD fall until cs_rise.
  - 0 in every other state.
  - Undriven QOUT bits are 0.
- cs_fall while not IDLE (CS glitch): treated as cs_rise followed by cs_fall, so a new frame starts.

## Timing
- Reset values:
  - state IDLE.
  - QSPI_QOUT = 0, QSPI_QOE = 0.
  - busy = 0, cmd_err = 0, xfer_done = 0.
  - All memory bytes = 0x00.
  - Sync flops load the idle levels SCLK=0 and CS_N=1.
- PRESET mid-frame aborts the frame. QOE drops on the next PCLK and no xfer_done is issued.
- Input-to-strobe latency: 3 PCLK.
- Output latency: QOUT/QOE change 3 PCLK after the external SCLK falling edge.
- Required master timing:
  - SCLK high and low phases are each ≥4 PCLK.
  - CS_N is low ≥4 PCLK before the first SCLK rise.
  - CS_N is high ≥4 PCLK between frames.
- busy rises 3 PCLK after CS_N falls and drops on the PCLK after cs_rise.
- dbg_data is combinational. A write becomes visible on dbg_data 1 PCLK after the byte-completing strobe.
- Simultaneous sclk_rise and cs_rise: cs_rise wins; the rise is ignored.
- Address wrap: with AW=4, a read burst starting at 0x0F returns mem[0x0F] then mem[0x00].

## Test plan
- Reset, then with dbg_addr = 0..15 -> dbg_data = 0x00 throughout. busy, QOE and cmd_err all 0.
- SPI write 0x02, addr 0x05, data 0xA5 0x3C, CS high -> mem[5]=0xA5, mem[6]=0x3C. xfer_done pulses once.
- Quad write 0x32 at addr 0x0E, data 0x11 0x22 0x33 -> mem[0x0E]=0x11, mem[0x0F]=0x22, mem[0x00]=0x33 (wrap).
- Dual read 0x3B at addr 0x05, DUMMY_CYC=4 -> QOE=0011 from the first data fall, master samples 0xA5 then 0x3C. QOE returns to 0 after CS high.
- Opcode 0x9F -> cmd_err=1, QOE stays 0, memory unchanged. The next frame's CS fall clears cmd_err.
- SPI write of addr 0x02 with CS raised after 5 data bits -> mem[2] unchanged, state IDLE. PRESET asserted mid-read -> QOE=0 on the next PCLK, busy=0.
